// File: rtl/rv_dmem_ctrl_pkg.sv
// Shared encodings and lane helpers for the data-memory controller.
package rv_dmem_ctrl_pkg;

    typedef enum logic [1:0] {
        SzB   = 2'b00,
        SzH   = 2'b01,
        SzW   = 2'b10,
        SzBad = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        StIdle,
        StRdWait,
        StResp
    } state_e;

    localparam logic [31:0] DefDmemBase = 32'h0001_0000;
    localparam logic [31:0] DefGpioAddr = 32'h0002_0000;

    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            SzB:     be = 4'b0001 << off;
            SzH:     be = 4'b0011 << off;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Right-aligned store data replicated so every lane carries it.
    function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] d;
        case (size)
            SzB:     d = {4{wdata[7:0]}};
            SzH:     d = {2{wdata[15:0]}};
            default: d = wdata;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] off,
                                             input logic [1:0] size, input logic uns);
        logic [31:0] s;
        logic [31:0] r;
        s = word >> {off, 3'b000};
        case (size)
            SzB:     r = uns ? {24'h0, s[7:0]} : {{24{s[7]}}, s[7:0]};
            SzH:     r = uns ? {16'h0, s[15:0]} : {{16{s[15]}}, s[15:0]};
            default: r = s;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/rv_dmem_ctrl_if.sv
// Core-side load/store bus with req/ready/rvalid handshake.
interface rv_dmem_ctrl_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, we, addr, size, uns, wdata,
        input  ready, rvalid, rdata, err
    );

    modport slave (
        input  req, we, addr, size, uns, wdata,
        output ready, rvalid, rdata, err
    );
endinterface

// File: rtl/rv_sram_be.sv
// DEPTH x 32 synchronous RAM with per-byte write enables and registered read.
module rv_sram_be #(
    parameter int unsigned DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic [3:0]               we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/rv_dmem_ctrl.sv
// Data-memory controller: DMEM window plus one GPIO register, byte/half/word access.
module rv_dmem_ctrl
    import rv_dmem_ctrl_pkg::*;
#(
    parameter logic [31:0] DMEM_BASE  = DefDmemBase,
    parameter int unsigned DMEM_DEPTH = 256,
    parameter logic [31:0] GPIO_ADDR  = DefGpioAddr,
    parameter int unsigned GPIO_W     = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    rv_dmem_ctrl_if.slave     bus,
    output logic [GPIO_W-1:0] gpio_o
);

    localparam int unsigned AW        = $clog2(DMEM_DEPTH);
    localparam logic [31:0] DmemBytes = 32'(4 * DMEM_DEPTH);

    state_e      state_q, state_d;
    logic        rvalid_q, rvalid_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic [GPIO_W-1:0] gpio_q, gpio_d;
    logic [1:0]  off_q, size_q;
    logic        uns_q, gpio_sel_q;

    logic [31:0] offset, lane, gpio_word, ram_rdata, rd_word;
    logic [3:0]  be, ram_we;
    logic        in_dmem, in_gpio, misalign, fault, accept, wr_ok, ram_en;

    assign bus.ready  = (state_q == StIdle) && !rst_i;
    assign bus.rvalid = rvalid_q;
    assign bus.err    = err_q;
    assign bus.rdata  = rdata_q;
    assign gpio_o     = gpio_q;

    assign offset   = bus.addr - DMEM_BASE;
    assign in_dmem  = (bus.addr >= DMEM_BASE) && (offset < DmemBytes);
    assign in_gpio  = bus.addr[31:2] == GPIO_ADDR[31:2];
    assign misalign = ((bus.size == SzH) && bus.addr[0]) ||
                      ((bus.size == SzW) && (bus.addr[1:0] != 2'b00));
    assign fault    = misalign || (bus.size == SzBad) || !(in_dmem || in_gpio);

    assign accept = bus.req && bus.ready;
    assign wr_ok  = accept && bus.we && !fault;
    assign be     = byte_en(bus.size, bus.addr[1:0]);
    assign lane   = lane_data(bus.size, bus.wdata);
    assign ram_en = accept && !fault && in_dmem;
    assign ram_we = (wr_ok && in_dmem) ? be : 4'b0000;

    rv_sram_be #(
        .DEPTH (DMEM_DEPTH)
    ) u_sram (
        .clk   (clk_i),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (offset[AW+1:2]),
        .wdata (lane),
        .rdata (ram_rdata)
    );

    always_comb begin
        gpio_word = '0;
        gpio_word[GPIO_W-1:0] = gpio_q;
    end

    assign rd_word = gpio_sel_q ? gpio_word : ram_rdata;

    // GPIO read-modify-write; lanes above GPIO_W are simply dropped.
    always_comb begin
        gpio_d = gpio_q;
        if (wr_ok && in_gpio && !in_dmem) begin
            for (int unsigned i = 0; i < GPIO_W; i++) begin
                if (be[i/8]) gpio_d[i] = lane[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        rdata_d = rdata_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = (fault || bus.we) ? StResp : StRdWait;
                    err_d   = fault;
                    if (fault || bus.we) rdata_d = '0;
                end
            end
            StRdWait: begin
                state_d = StResp;
                rdata_d = load_ext(rd_word, off_q, size_q, uns_q);
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        rvalid_d = (state_d == StResp);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            rvalid_q   <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            gpio_q     <= '0;
            off_q      <= '0;
            size_q     <= '0;
            uns_q      <= 1'b0;
            gpio_sel_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            gpio_q   <= gpio_d;
            if (accept) begin
                off_q      <= bus.addr[1:0];
                size_q     <= bus.size;
                uns_q      <= bus.uns;
                gpio_sel_q <= !in_dmem;
            end
        end
    end

endmodule
